// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scanner with per-key debounce
// and a sticky press-event register read by the AHB keyboard peripheral.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    input  logic        key_clear,
    output logic [15:0] key_data,
    output logic [15:0] key_down,
    output logic        key_irq
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]          row_m;
    logic [3:0]          row_s;
    logic [DW-1:0]       div;
    logic [1:0]          col;
    logic [1:0]          col_nx;
    logic [15:0]         snap;
    logic [15:0]         sample;
    logic [15:0]         down_nx;
    logic [15:0]         rise;
    logic [15:0][CW-1:0] cnt;
    logic [15:0][CW-1:0] cnt_nx;
    logic                at_sample;
    logic                scan_done;

    assign at_sample = (div == DIV_LAST);
    assign scan_done = at_sample && (col == 2'd3);
    assign col_nx    = col + 2'd1;
    assign rise      = down_nx & ~key_down;
    assign key_irq   = |key_data;

    // Two-flop synchronizer for the asynchronous row returns (idle high).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row_n;
            row_s <= row_m;
        end
    end

    // Slot divider and column rotation; col_n moves with col.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div   <= '0;
            col   <= 2'd0;
            col_n <= 4'b1110;
        end else if (at_sample) begin
            div   <= '0;
            col   <= col_nx;
            col_n <= ~(4'b0001 << col_nx);
        end else begin
            div   <= div + DW'(1);
        end
    end

    // Snapshot the active column's rows at the end of its slot.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            snap <= '0;
        end else if (at_sample) begin
            for (int r = 0; r < 4; r++) begin
                snap[{r[1:0], col}] <= ~row_s[r];
            end
        end
    end

    // Full-scan sample: column 3 comes straight from the synchronizer.
    always_comb begin
        sample = snap;
        for (int r = 0; r < 4; r++) begin
            sample[{r[1:0], 2'd3}] = ~row_s[r];
        end
    end

    // Per-key debounce: flip after DEBOUNCE_SCANS consecutive disagreements.
    always_comb begin
        down_nx = key_down;
        cnt_nx  = cnt;
        if (scan_done) begin
            for (int k = 0; k < 16; k++) begin
                if (sample[k] == key_down[k]) begin
                    cnt_nx[k] = '0;
                end else if (cnt[k] == CNT_LAST) begin
                    down_nx[k] = sample[k];
                    cnt_nx[k]  = '0;
                end else begin
                    cnt_nx[k] = cnt[k] + CW'(1);
                end
            end
        end
    end

    // Debounced state, counters and sticky events (set beats clear).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_down <= '0;
            cnt      <= '0;
            key_data <= '0;
        end else begin
            key_down <= down_nx;
            cnt      <= cnt_nx;
            key_data <= (key_clear ? 16'h0000 : key_data) | rise;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, directed scenarios and random
// presses/clears checked every cycle against a scan-level reference model.
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DS   = 2;
    localparam int SCAN = 4 * SD;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        key_clear = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_data;
    logic [15:0] key_down;
    logic        key_irq;
    logic [15:0] pressed = 16'h0000;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          t;
    logic [15:0] m_data;
    logic [15:0] m_down;
    logic [3:0]  m_coln;
    logic [15:0] hist [DS];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_clear(key_clear),
        .key_data (key_data),
        .key_down (key_down),
        .key_irq  (key_irq)
    );

    always #5 HCLK = ~HCLK;

    // Keypad matrix: a pressed key shorts its row to its driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_data = '0;
        m_down = '0;
        m_coln = 4'b1110;
        for (int i = 0; i < DS; i++) hist[i] = '0;
    endtask

    // Advance the model over the cycle that just ended: a key flips when
    // its last DS full-scan samples all disagree with its debounced level.
    task automatic model_edge(input logic [15:0] smp, input logic clr);
        logic [15:0] nd;
        logic [15:0] rise;
        rise = '0;
        if (t % SCAN == SCAN - 1) begin
            for (int i = DS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = smp;
            nd = m_down;
            for (int k = 0; k < 16; k++) begin
                bit flip;
                flip = 1'b1;
                for (int i = 0; i < DS; i++)
                    if (hist[i][k] == m_down[k]) flip = 1'b0;
                if (flip) nd[k] = ~m_down[k];
            end
            rise   = nd & ~m_down;
            m_down = nd;
        end
        m_data = (clr ? 16'h0000 : m_data) | rise;
        t++;
        m_coln = ~(4'b0001 << ((t / SD) % 4));
    endtask

    task automatic cyc();
        logic [15:0] p;
        logic        c;
        p = pressed;
        c = key_clear;
        @(posedge HCLK);
        if (HRESETn) model_edge(p, c);
        #1;
        key_clear = 1'b0;
    endtask

    task automatic run_scans(input logic [15:0] p, input int n);
        pressed = p;
        repeat (n * SCAN) cyc();
    endtask

    task automatic align();
        while (t % SCAN != 0) cyc();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".col_n"}, {12'h0, col_n}, 16'h000E);
        check({tag, ".key_data"}, key_data, 16'h0000);
        check({tag, ".key_down"}, key_down, 16'h0000);
        check({tag, ".key_irq"}, {15'h0, key_irq}, 16'h0000);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            check("cyc.col_n", {12'h0, col_n}, {12'h0, m_coln});
            check("cyc.key_down", key_down, m_down);
            check("cyc.key_data", key_data, m_data);
            check("cyc.key_irq", {15'h0, key_irq}, {15'h0, |m_data});
        end
    end

    logic [3:0] rot [4];

    initial begin
        rot = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        check_zero("reset");
        HRESETn = 1'b1;

        // Column rotation
        for (int i = 0; i < 4; i++) begin
            repeat (SD) cyc();
            check("rotate", {12'h0, col_n}, {12'h0, rot[i]});
        end

        // Clean press of key 5
        run_scans(16'h0020, 1);
        check("press1.key_down", key_down, 16'h0000);
        run_scans(16'h0020, 1);
        check("press2.key_down", key_down, 16'h0020);
        check("press2.key_data", key_data, 16'h0020);
        check("press2.key_irq", {15'h0, key_irq}, 16'h0001);

        // Release keeps the event, clear drops it
        run_scans(16'h0000, 2);
        check("release.key_down", key_down, 16'h0000);
        check("release.key_data", key_data, 16'h0020);
        key_clear = 1'b1;
        cyc();
        check("clear.key_data", key_data, 16'h0000);
        check("clear.key_irq", {15'h0, key_irq}, 16'h0000);
        align();

        // Bounce restarts the count
        run_scans(16'h0020, 1);
        run_scans(16'h0000, 1);
        run_scans(16'h0020, 1);
        check("bounce.key_down", key_down, 16'h0000);
        check("bounce.key_data", key_data, 16'h0000);
        run_scans(16'h0020, 1);
        check("bounce2.key_down", key_down, 16'h0020);
        run_scans(16'h0000, 2);

        // Collision: clear in the same cycle key 10 completes
        key_clear = 1'b1;
        run_scans(16'h0001, 2);
        check("coll.setup", key_data, 16'h0001);
        pressed = 16'h0400;
        repeat (SCAN) cyc();
        repeat (SCAN - 1) cyc();
        key_clear = 1'b1;
        cyc();
        check("coll.key_data", key_data, 16'h0400);

        // Keys 0 and 15 together
        key_clear = 1'b1;
        run_scans(16'h8001, 2);
        check("dual.key_data", key_data, 16'h8001);
        run_scans(16'h0000, 2);

        // Reset mid-scan with key 5 partly debounced
        run_scans(16'h0020, 1);
        repeat (2 * SD + 1) cyc();
        HRESETn = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        run_scans(16'h0020, 1);
        check("after_rst1.key_down", key_down, 16'h0000);
        run_scans(16'h0020, 1);
        check("after_rst2.key_down", key_down, 16'h0020);
        check("after_rst2.key_data", key_data, 16'h0020);

        // Random presses and clears
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 2) == 0)
                pressed = 16'($urandom) & 16'($urandom) & 16'($urandom);
            for (int c = 0; c < SCAN; c++) begin
                key_clear = ($urandom_range(0, 19) == 0);
                cyc();
            end
        end

        @(posedge HCLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scanning front end for a 4x4 active-low matrix keypad. Drives the keypad columns one at a time, synchronizes and debounces the row returns, and latches each debounced key-press into a sticky 16-bit event register. It feeds the AHB-Lite keyboard peripheral: `key_data` goes to that peripheral's read data, and that peripheral's one-cycle `key_clear` write strobe comes back here.

## Interface
- `SCAN_DIV`, default 1000: HCLK cycles each column is driven; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive full scans a key must disagree with its debounced state before that state flips; minimum 1.

- `HCLK`  in  1  system clock
- `HRESETn`  in  1  reset; asynchronous assert, active-low
- `col_n`  out  4  column drive, active-low; exactly one bit low at any time
- `row_n`  in  4  row returns, active-low, externally pulled up, asynchronous to HCLK
- `key_clear`  in  1  sampled every cycle; when high, clears all `key_data` bits
- `key_data`  out  16  sticky press events; bit k = row*4 + col
- `key_down`  out  16  debounced key level, same bit mapping
- `key_irq`  out  1  OR-reduction of `key_data`

## Operation
- `row_n` passes through a 2-flop synchronizer; all logic uses the synchronized value `row_s`.
- Slot counter `div` runs 0..SCAN_DIV-1. Column index `col` runs 0..3 and advances when `div` = SCAN_DIV-1. It wraps from 3 to 0.
- `col_n` = ~(1 << col), registered. It changes on the same edge as `col`.
- Sample point: the cycle with `div` = SCAN_DIV-1. In that cycle, snapshot bits {row3..row0}*4 + col are loaded with ~`row_s`.
- Scan complete: the sample point with col = 3. The debounce update uses the full 16-bit snapshot, with column 3 taken from the current `row_s`, not the registered copy.
- Debounce, per key k, with counter `cnt[k]` of width clog2(DEBOUNCE_SCANS+1):
  - If sample[k] == `key_down[k]`: `cnt[k]` <= 0.
  - Otherwise, if `cnt[k]` + 1 == DEBOUNCE_SCANS: `key_down[k]` <= sample[k] and `cnt[k]` <= 0.
  - Otherwise: `cnt[k]` increments.
  - A key that bounces back before reaching the threshold restarts from 0.
- Event: when `key_down[k]` transitions 0->1, `key_data[k]` is set. Release (1->0) never changes `key_data`.
- Clear: `key_clear` high in a cycle clears all `key_data` bits at the next edge. If a press event occurs in that same cycle, set wins for that bit and the other bits clear.
- Multiple keys completing debounce in the same scan set all their bits together.
- No ghosting suppression; reported bits follow raw matrix physics.

## Timing
- Reset values:
  - `col_n` = 4'b1110
  - `div` = 0, `col` = 0
  - `key_data` = 0, `key_down` = 0, `key_irq` = 0
  - all `cnt` = 0, snapshot = 0
- Reset mid-scan: takes effect asynchronously on all state and abandons the partial scan. The first scan after release starts at column 0.
- Full scan period = 4*SCAN_DIV cycles.
- Settling: `row_s` is sampled SCAN_DIV-1 edges after its column is driven. This is at least 3 edges, which covers the 2-flop synchronizer latency.
- `key_down` and `key_data` update on the edge at the end of the scan-complete cycle. `key_irq` is combinational from `key_data` and follows in the same cycle.
- Press-to-`key_data` latency with a clean, steady key: DEBOUNCE_SCANS scan completions after the first sample point that sees the key. Worst case is under (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- `key_clear` takes effect on the next edge, which is one cycle after the AHB write data phase.
- `key_data` must remain stable outside scan-complete and clear edges, so AHB reads are coherent.

## Test plan
- **Reset and rotation** (SCAN_DIV=4, DEBOUNCE_SCANS=2): after reset, `col_n` = 1110 and all outputs are 0. `col_n` then steps 1110->1101->1011->0111->1110, changing every 4 cycles.
- **Clean press:** a keypad model pulls `row_n[1]` low whenever `col_n[1]` = 0 (key 5). After 2 scan completions, `key_down` = 0x0020, `key_data` = 0x0020 and `key_irq` = 1. These update on the same edge.
- **Bounce:** key 5 is held for exactly 1 scan, released for 1 scan, then held again. No update occurs until 2 consecutive held scans, confirming the counter restarted.
- **Release and clear:** key 5 is released for 2 scans, giving `key_down` = 0 while `key_data` stays 0x0020. A 1-cycle `key_clear` then gives `key_data` = 0 and `key_irq` = 0 on the next edge.
- **Collision:** `key_data` = 0x0001 and `key_clear` is pulsed in the same cycle that key 10 completes debounce. Next cycle `key_data` = 0x0400. Separately, keys 0 and 15 pressed together both set, giving 0x8001.
- **Reset mid-scan:** `HRESETn` is asserted while col = 2 with key 5 partially debounced. `col_n` goes to 1110 immediately and all outputs and counters read 0. After release, a full DEBOUNCE_SCANS is required again.
